thermostat_controller: RTL

//  Downstream consumer of the temperature calculator's signed 32-bit tempc.

---
 rtl/thermostat_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/thermostat_controller.sv
// Thermostat controller: 4-sample moving average of tempc feeding a hysteresis
// heat/cool FSM with minimum dwell, plus a sticky range alarm that forces FAULT.
module thermostat_controller #(
    parameter int MIN_DWELL = 16,
    parameter int ALARM_CNT = 4,
    parameter int TEMP_MAX  = 60,
    parameter int TEMP_MIN  = -10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] tempc,
    input  logic               temp_valid,
    input  logic signed [31:0] setpoint,
    input  logic        [7:0]  hyst,
    input  logic               enable,
    input  logic               alarm_clr,
    output logic signed [31:0] avg_temp,
    output logic               avg_valid,
    output logic        [1:0]  state,
    output logic               heater_on,
    output logic               cooler_on,
    output logic               alarm
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int CW = $clog2(ALARM_CNT + 1);
    localparam logic [DW-1:0]     DWELL_LOAD = DW'(MIN_DWELL - 1);
    localparam logic [CW-1:0]     CNT_MAX    = CW'(ALARM_CNT);
    localparam logic signed [31:0] T_MAX     = 32'(TEMP_MAX);
    localparam logic signed [31:0] T_MIN     = 32'(TEMP_MIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HEAT  = 2'd1,
        S_COOL  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // The incoming sample is the fourth window entry, so only three past samples are stored.
    logic [2:0][31:0]   win_q, win_d;
    logic [2:0]         fill_q, fill_d;
    logic signed [31:0] avg_temp_q, avg_temp_d;
    logic signed [31:0] prev_avg_q, prev_avg_d;
    logic               avg_valid_q, avg_valid_d;
    state_t             state_q, state_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               alarm_q, alarm_d;

    logic signed [33:0] sum;
    logic signed [31:0] avg_new;
    logic signed [33:0] avg34, sp34, lo34, hi34;
    logic signed [31:0] judge_avg;
    logic               out_of_range, clr_ok, trip;
    logic [CW-1:0]      cnt_base;
    state_t             eval_state;

    assign sum     = 34'(tempc) + 34'($signed(win_q[0])) + 34'($signed(win_q[1]))
                   + 34'($signed(win_q[2]));
    assign avg_new = 32'(sum >>> 2);

    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        avg_temp_d  = avg_temp_q;
        prev_avg_d  = prev_avg_q;
        avg_valid_d = 1'b0;
        if (temp_valid) begin
            win_d[0] = tempc;
            win_d[1] = win_q[0];
            win_d[2] = win_q[1];
            if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
            if (fill_q >= 3'd3) begin
                avg_valid_d = 1'b1;
                avg_temp_d  = avg_new;
                prev_avg_d  = avg_temp_q;
            end
        end
    end

    assign avg34 = 34'(avg_temp_q);
    assign sp34  = 34'(setpoint);
    assign lo34  = sp34 - 34'(hyst);
    assign hi34  = sp34 + 34'(hyst);

    // A clear arriving with a fresh average is judged on the average before it.
    assign judge_avg    = avg_valid_q ? prev_avg_q : avg_temp_q;
    assign clr_ok       = alarm_clr && (state_q == S_FAULT)
                       && (judge_avg <= T_MAX) && (judge_avg >= T_MIN);
    assign out_of_range = (avg_temp_q > T_MAX) || (avg_temp_q < T_MIN);
    assign cnt_base     = clr_ok ? '0 : cnt_q;
    assign trip         = avg_valid_q && out_of_range && (cnt_base >= CNT_MAX - CW'(1));
    assign eval_state   = clr_ok ? S_IDLE : state_q;

    always_comb begin
        cnt_d   = cnt_base;
        alarm_d = alarm_q;
        if (avg_valid_q) begin
            if (!out_of_range)          cnt_d = '0;
            else if (cnt_base != CNT_MAX) cnt_d = cnt_base + CW'(1);
        end
        if (trip)        alarm_d = 1'b1;
        else if (clr_ok) alarm_d = 1'b0;
    end

    // FSM next state and dwell timer
    always_comb begin
        state_d = eval_state;
        if (trip) begin
            state_d = S_FAULT;
        end else if (eval_state != S_FAULT) begin
            if (!enable) begin
                state_d = S_IDLE;
            end else if (avg_valid_q) begin
                case (eval_state)
                    S_IDLE: begin
                        if (avg34 < lo34)      state_d = S_HEAT;
                        else if (avg34 > hi34) state_d = S_COOL;
                    end
                    S_HEAT: if (avg34 >= sp34 && dwell_q == '0) state_d = S_IDLE;
                    S_COOL: if (avg34 <= sp34 && dwell_q == '0) state_d = S_IDLE;
                    default: state_d = eval_state;
                endcase
            end
        end
        if ((state_d == S_HEAT || state_d == S_COOL) && state_d != state_q)
            dwell_d = DWELL_LOAD;
        else if (dwell_q != '0)
            dwell_d = dwell_q - DW'(1);
        else
            dwell_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q       <= '0;
            fill_q      <= '0;
            avg_temp_q  <= '0;
            prev_avg_q  <= '0;
            avg_valid_q <= 1'b0;
            state_q     <= S_IDLE;
            dwell_q     <= '0;
            cnt_q       <= '0;
            alarm_q     <= 1'b0;
        end else begin
            win_q       <= win_d;
            fill_q      <= fill_d;
            avg_temp_q  <= avg_temp_d;
            prev_avg_q  <= prev_avg_d;
            avg_valid_q <= avg_valid_d;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    always_comb begin
        state     = state_q;
        heater_on = (state_q == S_HEAT);
        cooler_on = (state_q == S_COOL);
        alarm     = alarm_q;
        avg_temp  = avg_temp_q;
        avg_valid = avg_valid_q;
    end

endmodule
